seg_scan_ctrl: RTL and testbench

Time-multiplexed display scan controller for the UART demo board. It receives bytes from the 9600-baud UART receiver and keeps a buffer of DIGITS decimal digits. It drives a single shared BCD-to-7-segment decoder with one digit at a time while rotating a one-hot digit enable. A guard interval at each digit change blanks all enables so that the shared segment bus never ghosts.

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_digit_buf.sv | 48 ++++
 rtl/seg_scan_ctrl.sv | 95 +++++++++
 tb/tb_seg_scan_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and scan state type for the display scan controller
package seg_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_ON    = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_digit_buf.sv
// rtl/seg_digit_buf.sv - digit shift buffer with received-byte decode and bad-character strobe
module seg_digit_buf
    import seg_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic [DIGITS*4-1:0]   digits_o,
    output logic                  char_err_o
);

    logic [DIGITS*4-1:0] buf_q, buf_d;
    logic                char_err_q, char_err_d;

    // Digit 0 occupies the low nibble; digits enter on the right and leave on the left.
    always_comb begin
        buf_d      = buf_q;
        char_err_d = 1'b0;
        if (valid_i) begin
            if (data_i >= CH_0 && data_i <= CH_9) begin
                buf_d = {buf_q[DIGITS*4-5:0], data_i[3:0]};
            end else if (data_i == CH_BS) begin
                buf_d = {BLANK_CODE, buf_q[DIGITS*4-1:4]};
            end else if (data_i == CH_CR) begin
                buf_d = {DIGITS{BLANK_CODE}};
            end else begin
                char_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q      <= {DIGITS{BLANK_CODE}};
            char_err_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            char_err_q <= char_err_d;
        end
    end

    assign digits_o   = buf_q;
    assign char_err_o = char_err_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed digit scan with guard blanking between slots
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 12500,
    parameter int GUARD    = 16
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [7:0]        iData,
    input  logic              iValid,
    output logic [3:0]        oDecimal,
    output logic [DIGITS-1:0] oDigitEn,
    output logic              oCharErr
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [DIGITS*4-1:0] digits;
    logic [3:0]          cur_digit;

    scan_state_e   state_q, state_d;
    logic [IW-1:0] index_q, index_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    seg_digit_buf #(
        .DIGITS (DIGITS)
    ) u_digit_buf (
        .clk_i      (iClk),
        .rst_i      (iRst),
        .data_i     (iData),
        .valid_i    (iValid),
        .digits_o   (digits),
        .char_err_o (oCharErr)
    );

    // The counter runs through the whole slot; the guard phase is its first GUARD counts.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            S_GUARD: begin
                if (cnt_q == GUARD_END) begin
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_GUARD;
                    cnt_d   = '0;
                    index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
                end
            end
            default: state_d = S_GUARD;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_GUARD;
            index_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cur_digit = BLANK_CODE;
        oDigitEn  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (index_q == IW'(i)) begin
                cur_digit = digits[i*4 +: 4];
            end
        end
        // A blank digit keeps its enable off so the decoder's blank output is never shown.
        for (int i = 0; i < DIGITS; i++) begin
            if (index_q == IW'(i) && state_q == S_ON && cur_digit != BLANK_CODE) begin
                oDigitEn[i] = 1'b1;
            end
        end
    end

    assign oDecimal = cur_digit;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized self-checking bench for seg_scan_ctrl against a slot-time model
module tb_seg_scan_ctrl;

    localparam int DG = 4;
    localparam int SD = 20;
    localparam int GD = 4;

    logic          iClk;
    logic          iRst;
    logic [7:0]    iData;
    logic          iValid;
    logic [3:0]    oDecimal;
    logic [DG-1:0] oDigitEn;
    logic          oCharErr;

    int n_vec;
    int n_err;

    // Reference state: digit values, cycles since reset release, pending error pulse.
    int mbuf[DG];
    int t;
    int merr;

    seg_scan_ctrl #(
        .DIGITS   (DG),
        .SCAN_DIV (SD),
        .GUARD    (GD)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iData    (iData),
        .iValid   (iValid),
        .oDecimal (oDecimal),
        .oDigitEn (oDigitEn),
        .oCharErr (oCharErr)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DG; i++) mbuf[i] = 15;
        t    = 0;
        merr = 0;
    endtask

    task automatic model_byte(input logic [7:0] d);
        if (d >= 8'h30 && d <= 8'h39) begin
            for (int i = DG - 1; i > 0; i--) mbuf[i] = mbuf[i-1];
            mbuf[0] = int'(d) - 48;
        end else if (d == 8'h08) begin
            for (int i = 0; i < DG - 1; i++) mbuf[i] = mbuf[i+1];
            mbuf[DG-1] = 15;
        end else if (d == 8'h0D) begin
            for (int i = 0; i < DG; i++) mbuf[i] = 15;
        end else begin
            merr = 1;
        end
    endtask

    function automatic int exp_idx();
        return (t / SD) % DG;
    endfunction

    function automatic int exp_en();
        int idx;
        idx = exp_idx();
        if ((t % SD) >= GD && mbuf[idx] != 15) return 1 << idx;
        return 0;
    endfunction

    // Entered just after a rising edge; checks this cycle's outputs, then advances the model.
    task automatic step(input logic v, input logic [7:0] d);
        iValid = v;
        iData  = d;
        @(negedge iClk);
        chk("decimal", 32'(oDecimal), 32'(mbuf[exp_idx()]));
        chk("digit_en", 32'(oDigitEn), 32'(exp_en()));
        chk("char_err", 32'(oCharErr), 32'(merr));
        @(posedge iClk);
        merr = 0;
        if (v) model_byte(d);
        t++;
        #1;
        iValid = 1'b0;
        iData  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return 8'(8'h30 + $urandom_range(0, 9));
        if (r == 6) return 8'h08;
        if (r == 7) return 8'h0D;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 4) step(1'b1, rand_byte());
            else step(1'b0, 8'h00);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        iRst   = 1'b1;
        iValid = 1'b0;
        iData  = 8'h00;
        model_reset();

        #3;
        chk("rst_decimal", 32'(oDecimal), 32'hF);
        chk("rst_digit_en", 32'(oDigitEn), 32'h0);
        chk("rst_char_err", 32'(oCharErr), 32'h0);
        @(posedge iClk);
        @(posedge iClk);
        #1;
        iRst = 1'b0;

        idle(2 * DG * SD);

        step(1'b1, 8'h31);
        step(1'b1, 8'h32);
        step(1'b1, 8'h33);
        step(1'b1, 8'h34);
        idle(DG * SD + 7);

        step(1'b1, 8'h35);
        idle(DG * SD);
        step(1'b1, 8'h08);
        idle(DG * SD);

        step(1'b1, 8'h41);
        idle(3);
        step(1'b1, 8'h0D);
        idle(DG * SD);

        step(1'b1, 8'h39);
        step(1'b1, 8'h38);
        for (int i = 0; i < SD && (t % SD) != SD - 1; i++) step(1'b0, 8'h00);
        chk("slot_edge_align", 32'(t % SD), 32'(SD - 1));
        step(1'b1, 8'h37);
        idle(DG * SD);

        random_run(800);

        step(1'b1, 8'h31);
        step(1'b1, 8'h32);
        step(1'b1, 8'h33);
        step(1'b1, 8'h34);
        for (int i = 0; i < 2 * SD && exp_en() == 0; i++) step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("pre_rst_on", 32'(exp_en() != 0), 32'd1);
        #2;
        iRst = 1'b1;
        #1;
        chk("async_decimal", 32'(oDecimal), 32'hF);
        chk("async_digit_en", 32'(oDigitEn), 32'h0);
        chk("async_char_err", 32'(oCharErr), 32'h0);
        model_reset();
        @(posedge iClk);
        @(posedge iClk);
        #1;
        iRst = 1'b0;

        idle(SD);
        step(1'b1, 8'h35);
        step(1'b1, 8'h36);
        idle(DG * SD);
        random_run(800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
